// File: rtl/aes_key_expander_seq.sv
// Iterative AES key schedule: loads the cipher key, then produces one
// 32-bit schedule word per clock into the flat expanded-key bus.

// Forward AES S-box as a flat lookup table, byte 0x00 in the top bits.
module AesSbox (
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut
);

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bitIndex;

  // Byte a sits at bit offset 8*(255-a), and 255-a is simply ~a.
  always_comb begin
    bitIndex = {~dataIn, 3'b000};
    dataOut  = SboxTable[bitIndex +: 8];
  end

endmodule

module aes_key_expander_seq #(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [255:0]           key_in,
  output logic                   busy,
  output logic                   done,
  output logic [128*(NR+1)-1:0]  full_key
);

  localparam int NW  = 4 * (NR + 1);
  localparam int FKW = 128 * (NR + 1);
  localparam int IW  = $clog2(NW);
  localparam int OW  = $clog2(FKW);

  typedef enum logic {IDLE, EXPAND} expandStateT;

  expandStateT     state;
  expandStateT     nextState;
  logic [IW-1:0]   wordIdx;
  logic [2:0]      modCnt;
  logic [7:0]      rcon;
  logic [7:0]      rconNext;
  logic [31:0]     window [NK];
  logic [FKW-1:0]  fullKey;
  logic [31:0]     prevWord;
  logic [31:0]     rotWord;
  logic [31:0]     sboxIn;
  logic [31:0]     subOut;
  logic [31:0]     temp;
  logic [31:0]     newWord;
  logic [OW-1:0]   writeBase;
  logic            atLastWord;
  logic            loadKey;
  logic            stepWord;
  logic            unusedKeyTail;

  // Key bits beyond 32*NK are ignored for the shorter key sizes.
  assign unusedKeyTail = ^key_in;

  assign full_key   = fullKey;
  assign busy       = (state == EXPAND);
  assign atLastWord = (wordIdx == IW'(NW - 1));

  // The window holds the last NK words: window[0] is w[i-NK], window[NK-1] is w[i-1].
  assign prevWord = window[NK-1];
  assign rotWord  = {prevWord[23:0], prevWord[31:24]};
  assign sboxIn   = (modCnt == 3'd0) ? rotWord : prevWord;
  assign rconNext = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // Word j lives at 32*(4*(j/4) + 3 - j%4), which is 32*(j with its low two bits flipped).
  assign writeBase = OW'({wordIdx ^ IW'(3), 5'b00000});

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gSubWord
      AesSbox uSbox (
        .dataIn  (sboxIn[8*g +: 8]),
        .dataOut (subOut[8*g +: 8])
      );
    end
  endgenerate

  // Pick the schedule transform for this word position and form w[i].
  always_comb begin
    temp = prevWord;
    if (modCnt == 3'd0) begin
      temp = subOut ^ {rcon, 24'h000000};
    end else if (NK == 8 && modCnt == 3'd4) begin
      temp = subOut;
    end
    newWord = window[0] ^ temp;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: accept start only when idle, stop after the last word.
  always_comb begin
    nextState = state;
    loadKey   = 1'b0;
    stepWord  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          loadKey   = 1'b1;
          nextState = EXPAND;
        end
      end
      EXPAND: begin
        stepWord = 1'b1;
        if (atLastWord) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: load the key words, then shift one new schedule word in per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fullKey <= '0;
      wordIdx <= '0;
      modCnt  <= '0;
      rcon    <= 8'h01;
      done    <= 1'b0;
      for (int k = 0; k < NK; k++) begin
        window[k] <= '0;
      end
    end else begin
      done <= stepWord && atLastWord;
      if (loadKey) begin
        for (int k = 0; k < NK; k++) begin
          window[k]                 <= key_in[255-32*k -: 32];
          fullKey[32*(k^3) +: 32]   <= key_in[255-32*k -: 32];
        end
        wordIdx <= IW'(NK);
        modCnt  <= '0;
        rcon    <= 8'h01;
      end else if (stepWord) begin
        for (int k = 0; k < NK - 1; k++) begin
          window[k] <= window[k+1];
        end
        window[NK-1]            <= newWord;
        fullKey[writeBase +: 32] <= newWord;
        wordIdx                 <= wordIdx + IW'(1);
        modCnt                  <= (modCnt == 3'(NK - 1)) ? 3'd0 : modCnt + 3'd1;
        if (modCnt == 3'd0) begin
          rcon <= rconNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq at NK = 4, 6 and 8.
module tb_aes_key_expander_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start4, start6, start8;
  logic [255:0] key4, key6, key8;
  logic         busy4, busy6, busy8;
  logic         done4, done6, done8;
  logic [1407:0] fk4;
  logic [1663:0] fk6;
  logic [1919:0] fk8;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [7:0] sboxRef [256];

  // 100 MHz style clock.
  always #5 clk = ~clk;

  aes_key_expander_seq #(.NK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .full_key(fk4));

  aes_key_expander_seq #(.NK(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .full_key(fk6));

  aes_key_expander_seq #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .full_key(fk8));

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sboxRef[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordRef(input logic [31:0] t);
    return {sboxRef[t[31:24]], sboxRef[t[23:16]], sboxRef[t[15:8]], sboxRef[t[7:0]]};
  endfunction

  // Reference key expansion straight from the schedule rules, packed as round keys.
  function automatic logic [1919:0] modelExpand(input int nk, input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nw;
    nw  = 4 * (nk + 7);
    res = '0;
    rc  = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWordRef(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) res[128*(i/4) + 32*(3 - i%4) +: 32] = w[i];
    return res;
  endfunction

  function automatic logic getDone(input int nk);
    return (nk == 4) ? done4 : (nk == 6) ? done6 : done8;
  endfunction

  function automatic logic getBusy(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  function automatic logic [1919:0] getFull(input int nk);
    return (nk == 4) ? {512'b0, fk4} : (nk == 6) ? {256'b0, fk6} : fk8;
  endfunction

  function automatic logic [255:0] randomKey();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One comparison; on mismatch, report the first differing 128-bit slice.
  task automatic checkOutput(input string tag, input logic [1919:0] observed,
                             input logic [1919:0] expected);
    int r;
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else begin
      r = 0;
      for (int k = 14; k >= 0; k--) begin
        if (observed[128*k +: 128] !== expected[128*k +: 128]) r = k;
      end
      $error("[TB] FAIL %s: observed %h required %h (128-bit slice %0d)", tag,
             observed[128*r +: 128], expected[128*r +: 128], r);
    end
  endtask

  // Pulse start for one sampling edge; caller is positioned away from the edge.
  task automatic applyStimulus(input int nk, input logic [255:0] key);
    if (nk == 4) begin key4 = key; start4 = 1'b1; end
    else if (nk == 6) begin key6 = key; start6 = 1'b1; end
    else begin key8 = key; start8 = 1'b1; end
    @(posedge clk);
    #1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  // Count edges until done is seen at a falling edge, within a budget.
  task automatic waitDone(input int nk, input int budget, output int cycles,
                          output bit seen, output bit busyEarly);
    cycles = 0; seen = 1'b0; busyEarly = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (c == 0) busyEarly = getBusy(nk);
      if (getDone(nk)) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Full run from idle: latency, busy and the whole expanded key.
  task automatic runAndCheck(input int nk, input logic [255:0] key, input string tag);
    int cycles;
    bit seen, busyEarly;
    applyStimulus(nk, key);
    waitDone(nk, 200, cycles, seen, busyEarly);
    checkOutput($sformatf("%s.busyAfterStart", tag), 1920'(busyEarly), 1920'(1));
    checkOutput($sformatf("%s.latency", tag), 1920'(cycles), 1920'(4 * (nk + 7) - nk));
    checkOutput($sformatf("%s.fullKey", tag), getFull(nk), modelExpand(nk, key));
  endtask

  logic [255:0] vec4, vec6, vec8, keyB, keyC;
  int           cyc;
  bit           seenDone, busyFirst;

  initial begin
    vec4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    vec6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    vec8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    buildSbox();

    // Reset, with a start request colliding with it: reset must win.
    rst = 1'b1; start4 = 1'b1; start6 = 1'b0; start8 = 1'b0;
    key4 = vec4; key6 = '0; key8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy4", 1920'(busy4), 1920'(0));
    checkOutput("reset.done4", 1920'(done4), 1920'(0));
    checkOutput("reset.fullKey4", getFull(4), '0);
    checkOutput("reset.fullKey8", getFull(8), '0);
    start4 = 1'b0;
    rst    = 1'b0;

    // Published AES-128 vector.
    runAndCheck(4, vec4, "nk4.vector");
    checkOutput("nk4.roundKey1", 1920'(fk4[255:128]), 1920'(128'ha0fafe1788542cb123a339392a6c7605));
    checkOutput("nk4.roundKey10", 1920'(fk4[1407:1280]), 1920'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    @(negedge clk);
    checkOutput("nk4.donePulseEnds", 1920'(done4), 1920'(0));
    checkOutput("nk4.idleNotBusy", 1920'(busy4), 1920'(0));

    // Published AES-192 and AES-256 vectors; random tail bits for AES-192 must be ignored.
    runAndCheck(6, {vec6[255:64], 64'($urandom)}, "nk6.vector");
    checkOutput("nk6.topRoundKey", 1920'(fk6[1663:1536]), 1920'(128'he98ba06f448c773c8ecc720401002202));
    runAndCheck(8, vec8, "nk8.vector");
    checkOutput("nk8.topRoundKey", 1920'(fk8[1919:1792]), 1920'(128'hfe4890d1e6188d0b046df344706c631e));

    // Reset in cycle 20 of an expansion aborts it without a done.
    @(negedge clk);
    applyStimulus(4, vec4);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort.busy", 1920'(busy4), 1920'(0));
    checkOutput("abort.fullKey", getFull(4), '0);
    rst = 1'b0;
    waitDone(4, 60, cyc, seenDone, busyFirst);
    checkOutput("abort.noDone", 1920'(seenDone), 1920'(0));
    runAndCheck(4, vec4, "abort.restart");

    // A second start while busy must not disturb the running expansion.
    keyB = randomKey();
    @(negedge clk);
    applyStimulus(4, vec4);
    repeat (9) @(negedge clk);
    applyStimulus(4, keyB);
    waitDone(4, 200, cyc, seenDone, busyFirst);
    checkOutput("busyStart.latency", 1920'(cyc), 1920'(31));
    checkOutput("busyStart.fullKey", getFull(4), modelExpand(4, vec4));

    // Start during the done cycle is accepted immediately.
    keyC = randomKey();
    applyStimulus(4, keyC);
    waitDone(4, 200, cyc, seenDone, busyFirst);
    checkOutput("doneStart.busy", 1920'(busyFirst), 1920'(1));
    checkOutput("doneStart.latency", 1920'(cyc), 1920'(40));
    checkOutput("doneStart.fullKey", getFull(4), modelExpand(4, keyC));

    // Random keys for every key size against the reference model.
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      runAndCheck(4, randomKey(), $sformatf("rand%0d.nk4", n));
      @(negedge clk);
      runAndCheck(6, randomKey(), $sformatf("rand%0d.nk6", n));
      @(negedge clk);
      runAndCheck(8, randomKey(), $sformatf("rand%0d.nk8", n));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/aes_key_expander_seq.md
# aes_key_expander_seq

Iterative AES key-schedule generator that sits directly upstream of the round-iterative decryption/encryption datapaths. It takes a cipher key, computes one 32-bit schedule word per clock, and publishes the complete expanded key as a flat bus. The round stages then index that bus by their round counter. A start/busy/done handshake tells the round sequencer when the bus is valid.

## Interface
- NK, 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
- NR, NK+6: round count (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request expansion of key_in; sampled only when idle.
- key_in  input  256  cipher key, left-justified; bits [255:256-32*NK] are used, remaining bits ignored.
- busy  output  1  high while expansion is in progress.
- done  output  1  single-cycle pulse; full_key is complete.
- full_key  output  128*(NR+1)  expanded key; round key r at bits [128*r+127 : 128*r], with r = {w[4r], w[4r+1], w[4r+2], w[4r+3]} and w[4r] most significant.

## Operation
- FSM states: IDLE and EXPAND.
- IDLE + start: load w[0..NK-1] from key_in (w[0] = key_in[255:224]). Set word index i = NK, i mod NK = 0, rcon = 8'h01, busy = 1. Go to EXPAND.
- EXPAND, one word per cycle. temp = w[i-1], then:
  - if i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and rcon <= xtime(rcon) (rcon sequence 01,02,04,08,10,20,40,80,1b,36).
  - else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp, written into its full_key slot.
  - increment i.
- Track i mod NK with its own wrapping counter; no divider.
- SubWord uses four instances of the codebase forward S-box.
- When w[4*NR+3] is written: busy <= 0, done <= 1 for one cycle, return to IDLE.
- full_key holds its value in IDLE until the next accepted start.
- start while busy: ignored, with no effect on the running expansion.

## Timing
- Reset values: busy = 0, done = 0, full_key = all zeros, state IDLE, rcon = 8'h01.
- rst asserted mid-expansion aborts it. Outputs return to reset values on the next edge, and no done is produced.
- rst and start in the same cycle: reset wins.
- C = 4*(NR+1) - NK words are computed: 40 (NK=4), 46 (NK=6), 52 (NK=8).
- If start is sampled at edge T:
  - key words appear at T.
  - w[NK+k] appears at edge T+1+k.
  - busy is high from after T until edge T+C.
  - done is high for exactly the cycle following edge T+C.
- start with done high (already IDLE) is accepted. full_key is then overwritten progressively and is valid only at the next done.
- Bits of full_key not yet written during EXPAND retain their previous contents; consumers use full_key only after done.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle:
  - done exactly 40 cycles later.
  - full_key[255:128] = a0fafe1788542cb123a339392a6c7605.
  - full_key[1407:1280] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-justified):
  - done after 46 cycles.
  - top round key = e98ba06f448c773c8ecc720401002202.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles.
  - top round key = fe4890d1e6188d0b046df344706c631e.
  - covers the i mod 8 == 4 SubWord path.
- NK=4, rst pulsed at cycle 20 of expansion: next cycle busy = 0 and full_key = 0. No done appears. A fresh start then yields the first vector after 40 cycles.
- NK=4:
  - a second start with a different key, issued while busy, is ignored: results equal the first vector.
  - start asserted in the done cycle is accepted: busy = 1 next cycle, and a second done after 40 cycles with the new key's schedule.
